// File: rtl/cpu_run_ctrl_if.sv
// Host/CPU-side signal bundle for the run controller.
// The master drives start/limit/CPU status/read index; the slave (controller) drives control, status and trace readout.
interface cpu_run_ctrl_if #(
    parameter int PC_W        = 9,
    parameter int CYC_W       = 16,
    parameter int TRACE_DEPTH = 16
);
    localparam int IW = $clog2(TRACE_DEPTH);

    logic             start;
    logic [CYC_W-1:0] max_cycles;
    logic             HALT;
    logic [PC_W-1:0]  PCFinal;
    logic             Zout;
    logic             Nout;
    logic             Vout;
    logic             cpu_reset;
    logic             enablePC;
    logic             busy;
    logic             done;
    logic             timeout;
    logic [CYC_W-1:0] cycle_count;
    logic [IW-1:0]    rd_idx;
    logic [PC_W+2:0]  rd_data;
    logic [IW:0]      trace_count;

    modport master (
        output start, max_cycles, HALT, PCFinal, Zout, Nout, Vout, rd_idx,
        input  cpu_reset, enablePC, busy, done, timeout, cycle_count, rd_data, trace_count
    );

    modport slave (
        input  start, max_cycles, HALT, PCFinal, Zout, Nout, Vout, rd_idx,
        output cpu_reset, enablePC, busy, done, timeout, cycle_count, rd_data, trace_count
    );
endinterface

// File: rtl/cpu_run_ctrl.sv
// CPU run controller: reset sequencing, PC enable, cycle limit, HALT/timeout termination.
// Optional PC/flag trace ring buffer when TRACE_EN is defined; all outputs registered.
module cpu_run_ctrl #(
    parameter int PC_W        = 9,
    parameter int CYC_W       = 16,
    parameter int RST_CYCLES  = 2,
    parameter int TRACE_DEPTH = 16
) (
    input  logic          clk,
    input  logic          reset,
    cpu_run_ctrl_if.slave bus
);
    localparam int IW  = $clog2(TRACE_DEPTH);
    localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RST, S_RUN, S_DONE} state_t;

    state_t           state;
    logic [RCW-1:0]   rst_cnt;
    logic [CYC_W-1:0] limit;
    logic [CYC_W-1:0] cyc;
    logic [CYC_W-1:0] cyc_inc;
    logic             cpu_reset_q;
    logic             enable_q;
    logic             busy_q;
    logic             done_q;
    logic             timeout_q;
    logic             start_acc;

    assign start_acc = bus.start && (state == S_IDLE || state == S_DONE);
    assign cyc_inc   = (&cyc) ? cyc : cyc + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            rst_cnt     <= '0;
            limit       <= '0;
            cyc         <= '0;
            cpu_reset_q <= 1'b1;
            enable_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start_acc) begin
                        state       <= S_RST;
                        rst_cnt     <= RCW'(RST_CYCLES - 1);
                        limit       <= bus.max_cycles;
                        cyc         <= '0;
                        cpu_reset_q <= 1'b1;
                        enable_q    <= 1'b0;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        timeout_q   <= 1'b0;
                    end
                end
                S_RST: begin
                    if (rst_cnt == '0) begin
                        state       <= S_RUN;
                        cpu_reset_q <= 1'b0;
                        enable_q    <= 1'b1;
                    end else begin
                        rst_cnt <= rst_cnt - 1'b1;
                    end
                end
                S_RUN: begin
                    cyc <= cyc_inc;
                    // HALT takes priority over the limit when both land on the same cycle
                    if (bus.HALT) begin
                        state     <= S_DONE;
                        enable_q  <= 1'b0;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        timeout_q <= 1'b0;
                    end else if (limit != '0 && cyc_inc == limit) begin
                        state     <= S_DONE;
                        enable_q  <= 1'b0;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        timeout_q <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.cpu_reset   = cpu_reset_q;
    assign bus.enablePC    = enable_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.timeout     = timeout_q;
    assign bus.cycle_count = cyc;

`ifdef TRACE_EN
    logic [PC_W+2:0] mem [TRACE_DEPTH];
    logic [IW-1:0]   wr_ptr;
    logic [IW:0]     tcount;
    logic [PC_W-1:0] last_pc;
    logic            have_last;
    logic [PC_W+2:0] rd_q;
    logic            trace_wr;
    logic            rd_hit;
    logic [IW-1:0]   rd_addr;

    // A new entry on the first RUN cycle and on every PC change thereafter
    assign trace_wr = (state == S_RUN) && (!have_last || bus.PCFinal != last_pc);
    // Once full the oldest entry sits at wr_ptr; addition wraps naturally
    assign rd_addr  = (tcount[IW] ? wr_ptr : '0) + bus.rd_idx;
    assign rd_hit   = {1'b0, bus.rd_idx} < tcount;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            tcount    <= '0;
            last_pc   <= '0;
            have_last <= 1'b0;
            rd_q      <= '0;
        end else begin
            rd_q <= rd_hit ? mem[rd_addr] : '0;
            if (start_acc) begin
                wr_ptr    <= '0;
                tcount    <= '0;
                have_last <= 1'b0;
            end else if (trace_wr) begin
                wr_ptr    <= wr_ptr + 1'b1;
                last_pc   <= bus.PCFinal;
                have_last <= 1'b1;
                if (!tcount[IW]) tcount <= tcount + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (trace_wr) mem[wr_ptr] <= {bus.Zout, bus.Nout, bus.Vout, bus.PCFinal};
    end

    assign bus.rd_data     = rd_q;
    assign bus.trace_count = tcount;
`else
    logic unused_trace;
    assign unused_trace    = ^{bus.rd_idx, bus.PCFinal, bus.Zout, bus.Nout, bus.Vout};
    assign bus.rd_data     = '0;
    assign bus.trace_count = '0;
`endif
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Randomized bench for cpu_run_ctrl with a queue-based reference model checked every cycle.
module tb_cpu_run_ctrl;
    localparam int PC_W        = 9;
    localparam int CYC_W       = 16;
    localparam int RST_CYCLES  = 2;
    localparam int TRACE_DEPTH = 16;
    localparam int IW          = $clog2(TRACE_DEPTH);

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    cpu_run_ctrl_if #(.PC_W(PC_W), .CYC_W(CYC_W), .TRACE_DEPTH(TRACE_DEPTH)) bus ();

    cpu_run_ctrl #(.PC_W(PC_W), .CYC_W(CYC_W), .RST_CYCLES(RST_CYCLES), .TRACE_DEPTH(TRACE_DEPTH))
        dut (.clk(clk), .reset(reset), .bus(bus));

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    typedef enum {M_IDLE, M_RST, M_RUN, M_DONE} mst_t;
    mst_t ms = M_IDLE;
    int   m_rst_left = 0;
    int   m_cyc = 0;
    int   m_lim = 0;
    bit   m_done = 0;
    bit   m_to = 0;
    bit   m_first = 0;
    int   m_last = 0;
    int   m_rd = 0;
    int   m_q[$];
    bit   m_valid = 0;

    always @(posedge clk) begin
        if (reset) begin
            ms = M_IDLE; m_cyc = 0; m_lim = 0; m_done = 0; m_to = 0;
            m_first = 0; m_rd = 0; m_q.delete(); m_valid = 1;
        end else begin
            m_rd = (int'(bus.rd_idx) < m_q.size()) ? m_q[int'(bus.rd_idx)] : 0;
            case (ms)
                M_IDLE, M_DONE: if (bus.start) begin
                    ms = M_RST; m_rst_left = RST_CYCLES; m_lim = int'(bus.max_cycles);
                    m_cyc = 0; m_done = 0; m_to = 0; m_first = 1; m_q.delete();
                end
                M_RST: begin
                    m_rst_left--;
                    if (m_rst_left == 0) ms = M_RUN;
                end
                M_RUN: begin
                    if (m_cyc < (1 << CYC_W) - 1) m_cyc++;
                    if (m_first || int'(bus.PCFinal) != m_last) begin
                        m_q.push_back((int'(bus.Zout) << (PC_W + 2)) | (int'(bus.Nout) << (PC_W + 1)) |
                                      (int'(bus.Vout) << PC_W) | int'(bus.PCFinal));
                        if (m_q.size() > TRACE_DEPTH) void'(m_q.pop_front());
                        m_first = 0;
                        m_last  = int'(bus.PCFinal);
                    end
                    if (bus.HALT) begin ms = M_DONE; m_done = 1; m_to = 0; end
                    else if (m_lim != 0 && m_cyc == m_lim) begin ms = M_DONE; m_done = 1; m_to = 1; end
                end
                default: ms = M_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("cpu_reset",   bus.cpu_reset,   (ms == M_IDLE || ms == M_RST) ? 1 : 0);
            chk("enablePC",    bus.enablePC,    (ms == M_RUN) ? 1 : 0);
            chk("busy",        bus.busy,        (ms == M_RST || ms == M_RUN) ? 1 : 0);
            chk("done",        bus.done,        m_done);
            chk("timeout",     bus.timeout,     m_to);
            chk("cycle_count", bus.cycle_count, m_cyc);
`ifdef TRACE_EN
            chk("trace_count", bus.trace_count, m_q.size());
            chk("rd_data",     bus.rd_data,     m_rd);
`else
            chk("trace_count", bus.trace_count, 0);
            chk("rd_data",     bus.rd_data,     0);
`endif
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [PC_W-1:0] pc_for(input int k, input int mode);
        case (mode)
            0:       return PC_W'(k - 1);
            1:       return PC_W'((k - 1) / 3);
            default: return PC_W'($urandom % 4);
        endcase
    endfunction

    // Called on a negedge; returns on the negedge where done is first visible.
    task automatic do_run(input int maxc, input int halt_at, input int mode, input bit noise,
                          output int k);
        bit fin;
        fin = 0;
        k   = 0;
        bus.start      = 1'b1;
        bus.max_cycles = CYC_W'(maxc);
        @(negedge clk);
        bus.start      = 1'b0;
        bus.max_cycles = CYC_W'($urandom);
        for (int i = 0; i < 400 && !fin; i++) begin
            bus.rd_idx = IW'($urandom);
            bus.start  = 1'b0;
            if (bus.done) begin
                fin = 1;
            end else if (bus.enablePC) begin
                k++;
                bus.HALT    = (k == halt_at);
                bus.PCFinal = pc_for(k, mode);
                {bus.Zout, bus.Nout, bus.Vout} = 3'($urandom);
                if (noise && k == 3) begin
                    bus.start      = 1'b1;
                    bus.max_cycles = CYC_W'($urandom_range(1, 3));
                end
            end else begin
                bus.HALT = 1'($urandom);
            end
            if (!fin) @(negedge clk);
        end
        bus.HALT  = 1'b0;
        bus.start = 1'b0;
        chk("run_finished_in_budget", fin, 1);
    endtask

    initial begin
        int k;
        bus.start = 0; bus.max_cycles = '0; bus.HALT = 0; bus.PCFinal = '0;
        bus.Zout = 0; bus.Nout = 0; bus.Vout = 0; bus.rd_idx = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_cpu_reset", bus.cpu_reset, 1);
        chk("reset_enablePC",  bus.enablePC, 0);
        chk("reset_busy",      bus.busy, 0);
        reset = 1'b0;
        @(negedge clk);

        // HALT on the 37th RUN cycle, generous limit
        do_run(500, 37, 0, 1'b0, k);
        chk("halt37_cycles",   bus.cycle_count, 37);
        chk("halt37_done",     bus.done, 1);
        chk("halt37_timeout",  bus.timeout, 0);
        chk("halt37_enablePC", bus.enablePC, 0);
        chk("halt37_cpu_reset", bus.cpu_reset, 0);

        // Limit of 20 with no HALT, PC stepping 0..19, start pulsed during RUN
        do_run(20, 0, 0, 1'b1, k);
        chk("limit20_run_cycles", k, 20);
        chk("limit20_cycles",     bus.cycle_count, 20);
        chk("limit20_timeout",    bus.timeout, 1);
        chk("limit20_done",       bus.done, 1);
        bus.rd_idx = IW'(0);
        @(negedge clk);
`ifdef TRACE_EN
        chk("trace_full_count", bus.trace_count, 16);
        chk("trace_oldest_pc",  bus.rd_data[PC_W-1:0], 4);
`else
        chk("trace_count_off",  bus.trace_count, 0);
        chk("rd_data_off",      bus.rd_data, 0);
`endif
        bus.rd_idx = IW'(15);
        @(negedge clk);
`ifdef TRACE_EN
        chk("trace_newest_pc",  bus.rd_data[PC_W-1:0], 19);
`else
        chk("rd_data_off_15",   bus.rd_data, 0);
`endif

        // HALT and limit on the same cycle: HALT wins
        do_run(5, 5, 0, 1'b0, k);
        chk("tie_timeout", bus.timeout, 0);
        chk("tie_cycles",  bus.cycle_count, 5);

        // PC held three cycles at a time: one entry per distinct PC
        do_run(0, 9, 1, 1'b0, k);
`ifdef TRACE_EN
        chk("hold_entries", bus.trace_count, 3);
`else
        chk("hold_entries_off", bus.trace_count, 0);
`endif

        // Synchronous reset in the middle of a run
        bus.start = 1'b1; bus.max_cycles = '0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (8) begin
            bus.PCFinal = PC_W'($urandom);
            bus.rd_idx  = IW'($urandom);
            @(negedge clk);
        end
        chk("midrun_busy", bus.busy, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("midrun_rst_cpu_reset",   bus.cpu_reset, 1);
        chk("midrun_rst_busy",        bus.busy, 0);
        chk("midrun_rst_cycle_count", bus.cycle_count, 0);
        chk("midrun_rst_trace_count", bus.trace_count, 0);
        reset = 1'b0;
        @(negedge clk);

        // Randomized runs, each checked against the limit/HALT rule as well as the model
        for (int r = 0; r < 8; r++) begin
            int maxc, halt_at, exp_cyc;
            bit exp_to;
            maxc    = ($urandom % 4 == 0) ? 0 : $urandom_range(1, 40);
            halt_at = $urandom_range(0, 45);
            if (maxc == 0 && halt_at == 0) halt_at = 10;
            exp_to  = !(halt_at != 0 && (maxc == 0 || halt_at <= maxc));
            exp_cyc = exp_to ? maxc : halt_at;
            do_run(maxc, halt_at, $urandom_range(0, 2), 1'($urandom), k);
            chk("rand_cycles",  bus.cycle_count, exp_cyc);
            chk("rand_timeout", bus.timeout, exp_to);
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Synthesizable run controller for the pipelined CPU top (`main`), replacing hand-written bench sequencing of `reset`/`enablePC` and fixed-length runs. It sequences CPU reset, enables the PC, counts executed cycles against a programmable limit, and terminates on `HALT` or timeout. An optional ring buffer captures the PC/flag trace for post-run readout. It sits beside `main`, driving its `reset` and `enablePC` inputs and observing `HALT`, `PCFinal`, `Zout`, `Nout` and `Vout`.

## Interface
- PC_W, 9, width of `PCFinal`
- CYC_W, 16, width of the cycle counter and limit
- RST_CYCLES, 2, cycles `cpu_reset` is held after start (≥1)
- TRACE_DEPTH, 16, trace entries (power of 2, ≥2)

- clk  in  1  single clock; all logic on posedge
- reset  in  1  synchronous, active-high
- start  in  1  pulse: begin run (honoured in IDLE/DONE only)
- max_cycles  in  CYC_W  run limit, sampled on accepted start; 0 = unlimited
- HALT  in  1  from CPU
- PCFinal  in  PC_W  from CPU
- Zout, Nout, Vout  in  1 each  CPU flags
- cpu_reset  out  1  drives CPU `reset`
- enablePC  out  1  drives CPU `enablePC`
- busy  out  1  in RST or RUN
- done  out  1  run finished (sticky until next start)
- timeout  out  1  run ended by limit, not HALT
- cycle_count  out  CYC_W  RUN cycles elapsed, saturating
- rd_idx  in  log2(TRACE_DEPTH)  trace read index, 0 = oldest
- rd_data  out  PC_W+3  {Z,N,V,PC} at rd_idx, registered
- trace_count  out  log2(TRACE_DEPTH)+1  valid entries

## Operation
- FSM states IDLE, RST, RUN, DONE. Reset → IDLE.
- Reset values: cpu_reset=1, enablePC=0, busy=0, done=0, timeout=0, cycle_count=0, trace_count=0, rd_data=0.
- IDLE: cpu_reset=1, enablePC=0. start → RST; latch max_cycles; clear cycle_count, done, timeout, trace pointers/count.
- RST: cpu_reset=1, enablePC=0, busy=1 for exactly RST_CYCLES cycles, then RUN.
- RUN: cpu_reset=0, enablePC=1, busy=1; cycle_count +1 per cycle, saturating at 2^CYC_W−1.
  - HALT=1 → DONE, done=1, timeout=0.
  - Otherwise, when max_cycles≠0 and the incremented count equals max_cycles → DONE, done=1, timeout=1.
  - HALT and limit reached in the same cycle: HALT wins (timeout=0).
- DONE: cpu_reset=0 (CPU state stays inspectable), enablePC=0, busy=0, done held. start → RST with the same clearing as IDLE.
- start while busy is ignored, with no effect on limit or counters.
- Trace write (RUN only): on the first RUN cycle, and thereafter whenever PCFinal differs from the last written PC, write {Zout,Nout,Vout,PCFinal} at wr_ptr. wr_ptr wraps modulo TRACE_DEPTH. trace_count saturates at TRACE_DEPTH. Once full, oldest entry = wr_ptr, and new writes overwrite it.
- Read: physical address = (full ? wr_ptr : 0) + rd_idx mod TRACE_DEPTH. rd_idx ≥ trace_count returns 0.

## Timing
- start sampled at posedge t; RST occupies t+1 … t+RST_CYCLES; first RUN cycle (enablePC=1) is t+RST_CYCLES+1.
- HALT sampled at posedge u in RUN: done=1 and enablePC=0 visible after u. The HALT cycle is counted.
- Limit N: exactly N RUN cycles, then DONE.
- rd_data latency: 1 cycle from rd_idx; valid in any state.
- Trace write is visible to the read port the cycle after the write.
- reset mid-run: next cycle is IDLE with all reset values, cpu_reset=1, and trace cleared.

## Configuration
- TRACE_EN defined: trace buffer, pointers, rd_data and trace_count as specified.
- TRACE_EN undefined: no trace storage; rd_data and trace_count tied to 0; FSM, counters and handshakes are unchanged.

## Test plan
- Reset, start with max_cycles=500, HALT raised on 37th RUN cycle → done=1, timeout=0, cycle_count=37, enablePC=0 next cycle.
- HALT never raised, max_cycles=20 → exactly 20 cycles with enablePC=1, then done=1, timeout=1, cycle_count=20.
- max_cycles=5, HALT on 5th RUN cycle → timeout=0, cycle_count=5.
- TRACE_EN, TRACE_DEPTH=16, PC stepping 0…19 → trace_count=16; rd_idx=0 gives PC 4, rd_idx=15 gives PC 19. PC held for 3 cycles produces one entry.
- start pulsed during RUN → ignored; synchronous reset asserted mid-RUN → next cycle cpu_reset=1, busy=0, cycle_count=0, trace_count=0.
- start in DONE → RST for RST_CYCLES cycles, counters cleared, second run completes normally.
